// File: rtl/mips_pkg.sv
// ============================================================================
//  Module : mips_pkg
//  Brief  : MIPS format codes, field bit positions and the field-to-word packer.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [1:0] FMT_R   = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_J   = 2'd2;
  localparam logic [1:0] FMT_BAD = 2'd3;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNC_HI  = 5;
  localparam int FUNC_LO  = 0;
  localparam int IMM16_HI = 15;
  localparam int IMM16_LO = 0;
  localparam int IMM26_HI = 25;
  localparam int IMM26_LO = 0;

  // Fields not used by the selected format are ignored; illegal format packs to zero.
  function automatic logic [31:0] pack_instr(
    input logic [1:0]  fmt,
    input logic [5:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [5:0]  func,
    input logic [15:0] imme16,
    input logic [25:0] imme26
  );
    logic [31:0] w;
    w = '0;
    case (fmt)
      FMT_R: begin
        w[OP_HI:OP_LO]       = op;
        w[RS_HI:RS_LO]       = rs;
        w[RT_HI:RT_LO]       = rt;
        w[RD_HI:RD_LO]       = rd;
        w[SHAMT_HI:SHAMT_LO] = shamt;
        w[FUNC_HI:FUNC_LO]   = func;
      end
      FMT_I: begin
        w[OP_HI:OP_LO]       = op;
        w[RS_HI:RS_LO]       = rs;
        w[RT_HI:RT_LO]       = rt;
        w[IMM16_HI:IMM16_LO] = imme16;
      end
      FMT_J: begin
        w[OP_HI:OP_LO]       = op;
        w[IMM26_HI:IMM26_LO] = imme26;
      end
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fifo.sv
// ============================================================================
//  Module : instr_fifo
//  Brief  : Synchronous FIFO with flush; push ignored when full, pop when empty.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

`default_nettype wire

// File: rtl/instr_packer.sv
// ============================================================================
//  Module : instr_packer
//  Brief  : Packs MIPS R/I/J fields into words and streams them to IMEM.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_packer
  import mips_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          restart,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    fmt,
  input  logic [5:0]                    op,
  input  logic [4:0]                    rs,
  input  logic [4:0]                    rt,
  input  logic [4:0]                    rd,
  input  logic [4:0]                    shamt,
  input  logic [5:0]                    func,
  input  logic [15:0]                   imme16,
  input  logic [25:0]                   imme26,
  output logic                          wr_en,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [31:0]                   wr_data,
  input  logic                          wr_ready,
  output logic [$clog2(MAX_WORDS):0]    words_written,
  output logic                          done,
  output logic                          err_pulse,
  output logic                          err_sticky
);

  localparam int CNT_W = $clog2(MAX_WORDS) + 1;
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic              fifo_full, fifo_empty;
  logic [OCC_W-1:0]  fifo_count;
  logic [31:0]       fifo_head, packed_word;
  logic              accept, push, pop, at_limit;
  logic [CNT_W:0]    in_flight;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic              done_q, done_d;
  logic              err_pulse_q, err_pulse_d;
  logic              err_sticky_q, err_sticky_d;

  // The word limit counts words still queued, so the FIFO can never overshoot it.
  always_comb begin
    in_flight   = {1'b0, words_q} + (CNT_W+1)'(fifo_count);
    at_limit    = (in_flight >= (CNT_W+1)'(MAX_WORDS));
    in_ready    = !fifo_full && !done_q && !restart && !rst && !at_limit;
    accept      = in_valid && in_ready;
    push        = accept && (fmt != FMT_BAD);
    pop         = !fifo_empty && wr_ready && !restart && !rst;
    packed_word = pack_instr(fmt, op, rs, rt, rd, shamt, func, imme16, imme26);
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (restart),
    .push      (push),
    .push_data (packed_word),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    addr_d       = addr_q;
    words_d      = words_q;
    done_d       = done_q;
    err_pulse_d  = 1'b0;
    err_sticky_d = err_sticky_q;
    if (restart) begin
      addr_d       = BASE_ADDR;
      words_d      = '0;
      done_d       = 1'b0;
      err_sticky_d = 1'b0;
    end else begin
      if (pop) begin
        addr_d  = addr_q + ADDR_W'(4);
        words_d = words_q + CNT_W'(1);
        if (words_d == CNT_W'(MAX_WORDS)) begin
          done_d = 1'b1;
        end
      end
      if (accept && (fmt == FMT_BAD)) begin
        err_pulse_d  = 1'b1;
        err_sticky_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= BASE_ADDR;
      words_q      <= '0;
      done_q       <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      words_q      <= words_d;
      done_q       <= done_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign wr_en         = !fifo_empty;
  assign wr_addr       = addr_q;
  assign wr_data       = fifo_empty ? 32'h0 : fifo_head;
  assign words_written = words_q;
  assign done          = done_q;
  assign err_pulse     = err_pulse_q;
  assign err_sticky    = err_sticky_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_packer.sv
// ============================================================================
//  Module : tb_instr_packer
//  Brief  : Randomized and directed bench for two instr_packer configurations.
//  Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_instr_packer;

  logic        clk = 1'b0;
  logic        rst, restart, in_valid, wr_ready;
  logic [1:0]  fmt;
  logic [5:0]  op, func;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imme16;
  logic [25:0] imme26;

  logic        a_in_ready, a_wr_en, a_done, a_err_pulse, a_err_sticky;
  logic [31:0] a_wr_addr, a_wr_data;
  logic [10:0] a_words;
  logic        b_in_ready, b_wr_en, b_done, b_err_pulse, b_err_sticky;
  logic [31:0] b_wr_addr, b_wr_data;
  logic [2:0]  b_words;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_packer #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'h0000_0000), .MAX_WORDS(1024)) dut_a (
    .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_ready(a_in_ready),
    .fmt(fmt), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
    .imme16(imme16), .imme26(imme26), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .wr_ready(wr_ready), .words_written(a_words), .done(a_done),
    .err_pulse(a_err_pulse), .err_sticky(a_err_sticky));

  instr_packer #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'hFFFF_FFF8), .MAX_WORDS(3)) dut_b (
    .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_ready(b_in_ready),
    .fmt(fmt), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
    .imme16(imme16), .imme26(imme26), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .wr_ready(wr_ready), .words_written(b_words), .done(b_done),
    .err_pulse(b_err_pulse), .err_sticky(b_err_sticky));

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut=%0d actual=%h expected=%h t=%0t", name, k, act, exp, $time);
    end
  endtask

  // Reference model: per configuration, a list of accepted words with head/tail indices.
  localparam int DEPTH = 4;
  int          maxw  [2] = '{1024, 3};
  logic [31:0] base  [2] = '{32'h0000_0000, 32'hFFFF_FFF8};
  logic [31:0] mlist [2][4096];
  int          wri [2], rdi [2], written [2];
  logic [31:0] maddr [2];
  bit          mdone [2], merrp [2], merrs [2];
  bit          started = 1'b0;

  function automatic logic [31:0] ref_pack();
    logic [31:0] w;
    case (fmt)
      2'd0: w = (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11)
              | (32'(shamt) << 6) | 32'(func);
      2'd1: w = (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imme16);
      2'd2: w = (32'(op) << 26) | 32'(imme26);
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  function automatic bit exp_ready(input int k);
    int occ;
    occ = wri[k] - rdi[k];
    return !rst && !restart && !mdone[k] && (occ < DEPTH) && (written[k] + occ < maxw[k]);
  endfunction

  initial begin : model
    bit acc, pop;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst || restart) begin
          rdi[k] = wri[k];
          maddr[k] = base[k];
          written[k] = 0;
          mdone[k] = 1'b0;
          merrp[k] = 1'b0;
          merrs[k] = 1'b0;
          if (rst) started = 1'b1;
        end else begin
          acc = in_valid && exp_ready(k);
          pop = (wri[k] > rdi[k]) && wr_ready;
          merrp[k] = acc && (fmt == 2'd3);
          if (merrp[k]) merrs[k] = 1'b1;
          if (pop) begin
            rdi[k]++;
            maddr[k] = maddr[k] + 32'd4;
            written[k]++;
            if (written[k] == maxw[k]) mdone[k] = 1'b1;
          end
          if (acc && (fmt != 2'd3)) begin
            mlist[k][wri[k] & 4095] = ref_pack();
            wri[k]++;
          end
        end
      end
    end
  end

  logic [31:0] b_log [64];
  int          b_logn = 0;

  initial begin : compare
    forever begin
      @(negedge clk);
      if (started) begin
        for (int k = 0; k < 2; k++) begin
          chk("in_ready", k, 32'(k == 0 ? a_in_ready : b_in_ready), 32'(exp_ready(k)));
          chk("wr_en", k, 32'(k == 0 ? a_wr_en : b_wr_en), 32'(wri[k] > rdi[k]));
          chk("wr_addr", k, (k == 0 ? a_wr_addr : b_wr_addr), maddr[k]);
          if (wri[k] > rdi[k])
            chk("wr_data", k, (k == 0 ? a_wr_data : b_wr_data), mlist[k][rdi[k] & 4095]);
          chk("words_written", k, (k == 0 ? 32'(a_words) : 32'(b_words)), 32'(written[k]));
          chk("done", k, 32'(k == 0 ? a_done : b_done), 32'(mdone[k]));
          chk("err_pulse", k, 32'(k == 0 ? a_err_pulse : b_err_pulse), 32'(merrp[k]));
          chk("err_sticky", k, 32'(k == 0 ? a_err_sticky : b_err_sticky), 32'(merrs[k]));
        end
        if (b_wr_en && wr_ready && !restart && !rst && b_logn < 64) begin
          b_log[b_logn] = b_wr_addr;
          b_logn++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  // Entered and left at posedge+1; completes once dut_a has accepted the field set.
  task automatic send(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s,
                      input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                      input logic [5:0] fn, input logic [15:0] i16, input logic [25:0] i26);
    int n;
    fmt = f; op = o; rs = s; rt = t; rd = d; shamt = sh; func = fn; imme16 = i16; imme26 = i26;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!a_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!a_in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready_low required=accept t=%0t", $time);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin : stim
    int nb;
    rst = 1'b1; restart = 1'b0; in_valid = 1'b0; wr_ready = 1'b1;
    fmt = '0; op = '0; rs = '0; rt = '0; rd = '0; shamt = '0; func = '0; imme16 = '0; imme26 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_wr_en", 0, 32'(a_wr_en), 32'd0);
    chk("rst_wr_addr", 0, a_wr_addr, 32'h0);
    chk("rst_wr_data", 0, a_wr_data, 32'h0);
    chk("rst_words", 0, 32'(a_words), 32'd0);
    chk("rst_done", 0, 32'(a_done), 32'd0);
    chk("rst_err_sticky", 0, 32'(a_err_sticky), 32'd0);
    chk("rst_in_ready", 0, 32'(a_in_ready), 32'd1);
    chk("rst_wr_addr", 1, b_wr_addr, 32'hFFFF_FFF8);
    step();

    send(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
    @(negedge clk);
    chk("r_wr_en", 0, 32'(a_wr_en), 32'd1);
    chk("r_wr_data", 0, a_wr_data, 32'h0022_1820);
    chk("r_wr_addr", 0, a_wr_addr, 32'h0);
    step();
    pulse_restart();

    send(2'd1, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0);
    @(negedge clk);
    chk("i_wr_data", 0, a_wr_data, 32'h2008_0005);
    chk("i_wr_addr", 0, a_wr_addr, 32'h0);
    step();
    send(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0100000);
    @(negedge clk);
    chk("j_wr_data", 0, a_wr_data, 32'h0810_0000);
    chk("j_wr_addr", 0, a_wr_addr, 32'h4);
    step();
    pulse_restart();

    send(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
    send(2'd3, 6'h3F, 5'd9, 5'd9, 5'd9, 5'd9, 6'h3F, 16'hFFFF, 26'h3FFFFFF);
    @(negedge clk);
    chk("bad_err_pulse", 0, 32'(a_err_pulse), 32'd1);
    chk("bad_err_sticky", 0, 32'(a_err_sticky), 32'd1);
    step();
    @(negedge clk);
    chk("bad_err_pulse_drop", 0, 32'(a_err_pulse), 32'd0);
    step();
    send(2'd0, 6'h00, 5'd4, 5'd5, 5'd6, 5'd0, 6'h22, 16'h0, 26'h0);
    repeat (3) step();
    @(negedge clk);
    chk("bad_words", 0, 32'(a_words), 32'd2);
    chk("bad_wr_addr", 0, a_wr_addr, 32'h8);
    chk("bad_sticky_hold", 0, 32'(a_err_sticky), 32'd1);
    step();
    pulse_restart();
    @(negedge clk);
    chk("restart_sticky_clr", 0, 32'(a_err_sticky), 32'd0);
    step();

    wr_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(2'd0, 6'h00, 5'd7, 5'd8, 5'(9 + i), 5'd0, 6'h25, 16'h0, 26'h0);
    @(negedge clk);
    chk("bp_in_ready", 0, 32'(a_in_ready), 32'd0);
    chk("bp_wr_data", 0, a_wr_data, 32'h00E8_4825);
    chk("bp_wr_addr", 0, a_wr_addr, 32'h0);
    repeat (3) step();
    @(negedge clk);
    chk("bp_hold_data", 0, a_wr_data, 32'h00E8_4825);
    chk("bp_hold_addr", 0, a_wr_addr, 32'h0);
    step();
    wr_ready = 1'b1;
    repeat (6) step();
    @(negedge clk);
    chk("bp_words", 0, 32'(a_words), 32'd4);
    chk("bp_wr_addr_end", 0, a_wr_addr, 32'h10);
    chk("bp_wr_en_end", 0, 32'(a_wr_en), 32'd0);
    step();

    pulse_restart();
    nb = b_logn;
    for (int i = 0; i < 3; i++)
      send(2'd1, 6'h09, 5'(i), 5'(i + 1), 5'd0, 5'd0, 6'h0, 16'(i * 3), 26'h0);
    repeat (4) step();
    @(negedge clk);
    chk("lim_done", 1, 32'(b_done), 32'd1);
    chk("lim_in_ready", 1, 32'(b_in_ready), 32'd0);
    chk("lim_words", 1, 32'(b_words), 32'd3);
    chk("lim_count", 1, 32'(b_logn - nb), 32'd3);
    chk("lim_addr0", 1, b_log[nb], 32'hFFFF_FFF8);
    chk("lim_addr1", 1, b_log[nb + 1], 32'hFFFF_FFFC);
    chk("lim_addr2", 1, b_log[nb + 2], 32'h0000_0000);
    step();

    wr_ready = 1'b0;
    pulse_restart();
    send(2'd0, 6'h00, 5'd1, 5'd1, 5'd1, 5'd1, 6'h01, 16'h0, 26'h0);
    send(2'd0, 6'h00, 5'd2, 5'd2, 5'd2, 5'd2, 6'h02, 16'h0, 26'h0);
    restart = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("rs_in_ready", 0, 32'(a_in_ready), 32'd0);
    step();
    restart = 1'b0;
    in_valid = 1'b0;
    wr_ready = 1'b1;
    @(negedge clk);
    chk("rs_wr_en", 0, 32'(a_wr_en), 32'd0);
    chk("rs_wr_addr", 0, a_wr_addr, 32'h0);
    chk("rs_words", 0, 32'(a_words), 32'd0);
    repeat (3) step();
    @(negedge clk);
    chk("rs_words_later", 0, 32'(a_words), 32'd0);
    step();

    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      fmt      = ($urandom_range(0, 7) == 7) ? 2'd3 : 2'($urandom_range(0, 2));
      op       = 6'($urandom);
      rs       = 5'($urandom);
      rt       = 5'($urandom);
      rd       = 5'($urandom);
      shamt    = 5'($urandom);
      func     = 6'($urandom);
      imme16   = 16'($urandom);
      imme26   = 26'($urandom);
      wr_ready = ($urandom_range(0, 9) < 7);
      restart  = ($urandom_range(0, 149) == 0);
      rst      = ($urandom_range(0, 499) == 0);
      step();
    end
    in_valid = 1'b0;
    restart  = 1'b0;
    rst      = 1'b0;
    wr_ready = 1'b1;
    repeat (10) step();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
